aska_hbridge_drv: RTL

- Output conditioning stage placed directly downstream of the stimulation pulse generator, in front of the analog H-bridge and current DAC pads.
- Takes the requested up/down switch patterns and DAC code, and inserts break-before-make dead time whenever a switch closes.
- Blocks shoot-through (P and N switch of one electrode both on).
- Optional watchdog forces safe state if pulse_active stays high too long; faults latch until explicitly cleared.

---
 rtl/aska_hbridge_drv.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/aska_hbridge_drv.sv
// ----------------------------------------------------------------------------
// aska_hbridge_drv
//
// Output conditioning stage between the stimulation pulse generator and the
// analog H-bridge / current DAC pads. Switch closures get a break-before-make
// interval (DEADTIME cycles). Openings and pure DAC changes pass through with
// one cycle of latency. A request that closes the P and N switch of the same
// electrode is treated as a fault and forces the safe state (all switches
// open, DAC 0). The fault latches until fault_clr is raised while every
// request is idle.
//
// Optional feature, enabled by defining ASKA_HBRIDGE_WATCHDOG_EN:
//   a watchdog counts consecutive cycles of pulse_active_in=1. If the input is
//   still high once the count has saturated at MAX_ON, the block faults with
//   code 2'b10. Without the macro no counter exists and MAX_ON is unused.
//
// Parameters:
//   N_ELE    electrode count (width of each switch bus)
//   DAC_W    DAC code width
//   DEADTIME break-before-make interval in clk cycles, 1..15
//   MAX_ON   watchdog limit in cycles
//
// Ports:
//   clk              stimulation clock
//   reset            asynchronous reset, active-high
//   up_req/down_req  requested P/N switch patterns
//   dac_req          requested DAC code
//   pulse_active_in  pulse generator activity flag
//   fault_clr        level request to leave the fault state
//   up_sw/down_sw    conditioned P/N switch drive (registered)
//   dac_out          conditioned DAC code (registered)
//   pulse_active_out registered activity flag, 0 while faulted
//   fault            latched fault indicator
//   fault_code       00 none, 01 shoot-through, 10 watchdog
// ----------------------------------------------------------------------------
module aska_hbridge_drv #(
  parameter int N_ELE    = 32,
  parameter int DAC_W    = 6,
  parameter int DEADTIME = 1,
  parameter int MAX_ON   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_ELE-1:0] up_req,
  input  logic [N_ELE-1:0] down_req,
  input  logic [DAC_W-1:0] dac_req,
  input  logic             pulse_active_in,
  input  logic             fault_clr,
  output logic [N_ELE-1:0] up_sw,
  output logic [N_ELE-1:0] down_sw,
  output logic [DAC_W-1:0] dac_out,
  output logic             pulse_active_out,
  output logic             fault,
  output logic [1:0]       fault_code
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_BREAK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_SHOOT = 2'b01;
  localparam logic [1:0] CODE_WDOG  = 2'b10;

  // Entering S_BREAK already consumes one edge, so the count starts at
  // DEADTIME-1 and the hold registers are applied on the edge it reads 0.
  localparam logic [3:0] DT_LOAD = 4'(DEADTIME - 1);

  state_t             state, state_nxt;
  logic [N_ELE-1:0]   hold_up, hold_up_nxt;
  logic [N_ELE-1:0]   hold_down, hold_down_nxt;
  logic [DAC_W-1:0]   hold_dac, hold_dac_nxt;
  logic [3:0]         dt_cnt, dt_cnt_nxt;
  logic [N_ELE-1:0]   up_nxt, down_nxt;
  logic [DAC_W-1:0]   dac_nxt;
  logic               pa_nxt, fault_nxt;
  logic [1:0]         code_nxt;

  logic [2*N_ELE-1:0] applied, target;
  logic               closing, shoot, wd_trip, exit_ok;

  assign applied = {up_sw, down_sw};
  assign target  = {up_req, down_req};
  assign closing = |(target & ~applied);
  assign shoot   = |(up_req & down_req);
  assign exit_ok = fault_clr && (up_req == '0) && (down_req == '0) && !pulse_active_in;

`ifdef ASKA_HBRIDGE_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_ON + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_ON);

  logic [WD_W-1:0] wd_cnt;

  // Counts consecutive active cycles, saturating at MAX_ON. It keeps
  // counting while faulted; leaving the fault state clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (!pulse_active_in || (state == S_FAULT && exit_ok)) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_trip = pulse_active_in && (wd_cnt == WD_MAX);
`else
  assign wd_trip = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    up_nxt        = up_sw;
    down_nxt      = down_sw;
    dac_nxt       = dac_out;
    pa_nxt        = pulse_active_in;
    fault_nxt     = fault;
    code_nxt      = fault_code;
    hold_up_nxt   = hold_up;
    hold_down_nxt = hold_down;
    hold_dac_nxt  = hold_dac;
    dt_cnt_nxt    = dt_cnt;

    case (state)
      S_RUN, S_BREAK: begin
        if (shoot || wd_trip) begin
          // Safety checks are live in both states and preempt a break.
          state_nxt  = S_FAULT;
          up_nxt     = '0;
          down_nxt   = '0;
          dac_nxt    = '0;
          pa_nxt     = 1'b0;
          fault_nxt  = 1'b1;
          code_nxt   = shoot ? CODE_SHOOT : CODE_WDOG;
          dt_cnt_nxt = '0;
        end else if (state == S_RUN) begin
          if (closing) begin
            // Open what must open now, keep common switches closed, and
            // park the full request until the dead time has elapsed.
            hold_up_nxt   = up_req;
            hold_down_nxt = down_req;
            hold_dac_nxt  = dac_req;
            up_nxt        = up_sw & up_req;
            down_nxt      = down_sw & down_req;
            dac_nxt       = '0;
            dt_cnt_nxt    = DT_LOAD;
            state_nxt     = S_BREAK;
          end else begin
            up_nxt   = up_req;
            down_nxt = down_req;
            dac_nxt  = dac_req;
          end
        end else begin
          if (dt_cnt != 4'd0) begin
            dt_cnt_nxt = dt_cnt - 4'd1;
          end else begin
            up_nxt    = hold_up;
            down_nxt  = hold_down;
            dac_nxt   = hold_dac;
            state_nxt = S_RUN;
          end
        end
      end

      S_FAULT: begin
        up_nxt   = '0;
        down_nxt = '0;
        dac_nxt  = '0;
        pa_nxt   = 1'b0;
        if (exit_ok) begin
          state_nxt = S_RUN;
          fault_nxt = 1'b0;
          code_nxt  = CODE_NONE;
        end
      end

      default: begin
        state_nxt = S_RUN;
        up_nxt    = '0;
        down_nxt  = '0;
        dac_nxt   = '0;
        pa_nxt    = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_sw            <= '0;
      down_sw          <= '0;
      dac_out          <= '0;
      pulse_active_out <= 1'b0;
      fault            <= 1'b0;
      fault_code       <= CODE_NONE;
      hold_up          <= '0;
      hold_down        <= '0;
      hold_dac         <= '0;
      dt_cnt           <= '0;
    end else begin
      up_sw            <= up_nxt;
      down_sw          <= down_nxt;
      dac_out          <= dac_nxt;
      pulse_active_out <= pa_nxt;
      fault            <= fault_nxt;
      fault_code       <= code_nxt;
      hold_up          <= hold_up_nxt;
      hold_down        <= hold_down_nxt;
      hold_dac         <= hold_dac_nxt;
      dt_cnt           <= dt_cnt_nxt;
    end
  end

endmodule
